pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning program-counter width.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the PC value loaded in INIT.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1, a debug command is present this cycle.
REQ-006 SHALL have port cmd_code, input, 2, command: 0=RUN, 1=STEP, 2=HALT, 3=CLEAR.
REQ-007 SHALL have port stall_req, input, 1, load-use hazard; the PC must hold.
REQ-008 SHALL have port branch_valid, input, 1, taken branch/jump redirect this cycle.
REQ-009 SHALL have port branch_target, input, PC_W, redirect address.
REQ-010 SHALL have port instr_halt, input, 1, fetched instruction is HALT.
REQ-011 SHALL have port pc_enable, output, 1, drives the PC register enable.
REQ-012 SHALL have port pc_salto, output, 1, selects the jump input of the PC register.
REQ-013 SHALL have port pc_con_salto, output, PC_W, the jump address presented to the PC register.
REQ-014 SHALL have port cmd_ack, output, 1, one-cycle pulse when a command is accepted.
REQ-015 SHALL have port step_done, output, 1, one-cycle pulse when a STEP advance completes.
REQ-016 SHALL have port halted, output, 1, high in HALTED state.
REQ-017 SHALL have port advance_count, output, 32, number of cycles with pc_enable=1.

Function
REQ-018 SHALL implement states INIT, IDLE, RUN, STEP, HALTED.
REQ-019 INIT SHALL last exactly one cycle with pc_enable=1, pc_salto=1, pc_con_salto=RESET_VECTOR, then go to IDLE.
REQ-020 Command acceptance SHALL be: RUN and STEP only in IDLE or HALTED; HALT only in RUN; CLEAR in any state. cmd_ack pulses the same cycle. Other commands are ignored without an ack.
REQ-021 RUN SHALL go to RUN. STEP SHALL go to STEP. HALT SHALL go to HALTED. CLEAR SHALL go to INIT, zero advance_count and drop any pending branch.
REQ-022 In RUN and STEP, pc_enable SHALL equal NOT stall_req. In IDLE and HALTED, pc_enable SHALL be 0.
REQ-023 When a redirect is applied, pc_salto SHALL be 1 and pc_con_salto SHALL carry the redirect target. Otherwise pc_salto=0 and pc_con_salto=0.
REQ-024 A redirect SHALL be applied on the first cycle with pc_enable=1 for which a redirect exists. The source SHALL be branch_valid if asserted that cycle, otherwise the pending branch.
REQ-025 If branch_valid is asserted on a cycle with pc_enable=0, the target SHALL be latched as pending. A newer branch_valid SHALL overwrite the pending target. The pending branch SHALL be cleared when applied.
REQ-026 STEP SHALL wait through stalls and perform exactly one advance, then go to IDLE with step_done=1 on that advance cycle.
REQ-027 instr_halt in RUN or STEP SHALL force pc_enable=0 that cycle and go to HALTED. A simultaneous branch SHALL be kept as pending.
REQ-028 If HALT is commanded in the same cycle as instr_halt, the result SHALL be HALTED with cmd_ack=1.
REQ-029 A CLEAR in the same cycle as any other event SHALL take priority.
REQ-030 advance_count SHALL increment on every pc_enable=1 cycle, including INIT, and SHALL saturate at 32'hFFFF_FFFF.
REQ-031 All outputs except pc_enable, pc_salto and pc_con_salto SHALL be registered. Those three are combinational from state, stall_req, branch_valid, branch_target and instr_halt.

Reset
REQ-032 reset=0 SHALL asynchronously force: state INIT, pending branch cleared, advance_count=0, cmd_ack=0, step_done=0, halted=0.
REQ-033 After reset is released, the first clock edge SHALL complete INIT, so the PC loads RESET_VECTOR.
REQ-034 Reset asserted mid-STEP or mid-RUN SHALL abandon the operation and SHALL NOT produce step_done.

Structure
REQ-035 The state encoding, the cmd_code values and RESET_VECTOR SHALL live in a shared package used by the debug unit.
REQ-036 The block SHALL contain one sub-module, pc_branch_latch, holding the pending-branch valid flag and target.

Verification
REQ-037 Reset release with RESET_VECTOR=0x100 -> one cycle with pc_enable=1, pc_salto=1, target 0x100, then IDLE with pc_enable=0.
REQ-038 RUN, then stall_req high for 2 cycles with branch_valid (target 0x40) in the first stall cycle -> pc_enable=0 for 2 cycles, then pc_salto=1 with target 0x40 on the next cycle.
REQ-039 STEP issued while stall_req is high for 3 cycles -> cmd_ack pulse, then exactly one pc_enable pulse after the stall, with step_done high on that cycle, then IDLE.
REQ-040 RUN, then instr_halt and branch_valid (0x80) in the same cycle -> HALTED with halted=1; a following RUN -> first advance uses pc_salto=1 with target 0x80.
REQ-041 CLEAR issued in RUN with advance_count=10 -> INIT cycle, advance_count reads 1 after INIT, pending branch dropped.
REQ-042 STEP issued in RUN -> no cmd_ack and RUN continues; advance_count preset near 0xFFFF_FFFF -> it saturates and does not wrap.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer and the debug unit: sequencer states,
// debug command codes, default reset vector and the saturating cycle counter helper.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_HALTED = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        CMD_RUN   = 2'd0,
        CMD_STEP  = 2'd1,
        CMD_HALT  = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd_code_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] COUNT_MAX            = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == COUNT_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pc_sequencer_branch_latch.sv
// Holds a taken-branch target that arrived while the PC was frozen, until the
// sequencer can apply it on the next advancing cycle.
module pc_branch_latch #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            load,
    input  logic [PC_W-1:0] load_target,
    output logic            pending,
    output logic [PC_W-1:0] pending_target
);

    logic            pending_reg;
    logic [PC_W-1:0] target_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_reg <= 1'b0;
            target_reg  <= '0;
        end else if (clear) begin
            pending_reg <= 1'b0;
        end else if (load) begin
            pending_reg <= 1'b1;
            target_reg  <= load_target;
        end
    end

    assign pending        = pending_reg;
    assign pending_target = target_reg;

endmodule

// File: rtl/pc_sequencer.sv
// Debug-controlled program-counter sequencer: drives the PC register enable and
// jump select, deferring redirects that arrive while the PC is stalled or halted.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(DEFAULT_RESET_VECTOR)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    input  logic [1:0]      cmd_code,
    input  logic            stall_req,
    input  logic            branch_valid,
    input  logic [PC_W-1:0] branch_target,
    input  logic            instr_halt,
    output logic            pc_enable,
    output logic            pc_salto,
    output logic [PC_W-1:0] pc_con_salto,
    output logic            cmd_ack,
    output logic            step_done,
    output logic            halted,
    output logic [31:0]     advance_count
);

    seq_state_t      state_reg;
    logic            cmd_ack_reg;
    logic            step_done_reg;
    logic            halted_reg;
    logic [31:0]     advance_count_reg;

    logic            pending;
    logic [PC_W-1:0] pending_target;
    logic            redirect_apply;
    logic            clear_cmd;

    assign clear_cmd = cmd_valid && (cmd_code == CMD_CLEAR);

    always_comb begin
        pc_enable      = 1'b0;
        pc_salto       = 1'b0;
        pc_con_salto   = '0;
        redirect_apply = 1'b0;
        case (state_reg)
            ST_INIT: begin
                pc_enable    = 1'b1;
                pc_salto     = 1'b1;
                pc_con_salto = RESET_VECTOR;
            end
            ST_RUN, ST_STEP: begin
                // A fetched HALT freezes the PC immediately, same as a stall.
                pc_enable = !stall_req && !instr_halt;
                if (!stall_req && !instr_halt && (branch_valid || pending)) begin
                    redirect_apply = 1'b1;
                    pc_salto       = 1'b1;
                    pc_con_salto   = branch_valid ? branch_target : pending_target;
                end
            end
            default: ;
        endcase
    end

    pc_branch_latch #(
        .PC_W(PC_W)
    ) u_branch_latch (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear_cmd || redirect_apply),
        .load           (branch_valid && !pc_enable && !clear_cmd),
        .load_target    (branch_target),
        .pending        (pending),
        .pending_target (pending_target)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= ST_INIT;
            cmd_ack_reg       <= 1'b0;
            step_done_reg     <= 1'b0;
            halted_reg        <= 1'b0;
            advance_count_reg <= 32'd0;
        end else begin
            cmd_ack_reg       <= 1'b0;
            step_done_reg     <= 1'b0;
            advance_count_reg <= pc_enable ? sat_inc(advance_count_reg) : advance_count_reg;
            if (clear_cmd) begin
                state_reg         <= ST_INIT;
                cmd_ack_reg       <= 1'b1;
                halted_reg        <= 1'b0;
                advance_count_reg <= 32'd0;
            end else begin
                case (state_reg)
                    ST_INIT: state_reg <= ST_IDLE;
                    ST_IDLE, ST_HALTED: begin
                        if (cmd_valid && (cmd_code == CMD_RUN)) begin
                            state_reg   <= ST_RUN;
                            cmd_ack_reg <= 1'b1;
                            halted_reg  <= 1'b0;
                        end else if (cmd_valid && (cmd_code == CMD_STEP)) begin
                            state_reg   <= ST_STEP;
                            cmd_ack_reg <= 1'b1;
                            halted_reg  <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (cmd_valid && (cmd_code == CMD_HALT)) begin
                            state_reg   <= ST_HALTED;
                            cmd_ack_reg <= 1'b1;
                            halted_reg  <= 1'b1;
                        end else if (instr_halt) begin
                            state_reg  <= ST_HALTED;
                            halted_reg <= 1'b1;
                        end
                    end
                    ST_STEP: begin
                        if (instr_halt) begin
                            state_reg  <= ST_HALTED;
                            halted_reg <= 1'b1;
                        end else if (!stall_req) begin
                            state_reg     <= ST_IDLE;
                            step_done_reg <= 1'b1;
                        end
                    end
                    default: state_reg <= ST_INIT;
                endcase
            end
        end
    end

    assign cmd_ack       = cmd_ack_reg;
    assign step_done     = step_done_reg;
    assign halted        = halted_reg;
    assign advance_count = advance_count_reg;

endmodule
